adder_result_accumulator: RTL and testbench
===========================================

// Module: adder_result_accumulator
// PURPOSE
//   Downstream stage of eight_bit_adder. Consumes {carry_out, result} beats over a valid/ready
//   handshake and sums a batch of COUNT_N beats into a wider accumulator.
//   Presents the batch total on an output handshake. Flags overflow.
//   Turns the combinational adder into a multi-sample summing datapath.
// PARAMETERS
//   DATA_W   8   width of adder result input (carry_out is one extra bit)
//   ACC_W    16  accumulator width; must be >= DATA_W+1
//   COUNT_N  4   beats per batch; must be >= 1
// PORTS
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   start      in   1       begin a new batch (sampled in IDLE or DONE)
//   in_valid   in   1       result/carry_out beat valid
//   in_ready   out  1       stage accepts a beat
//   result     in   DATA_W  adder sum bits
//   carry_out  in   1       adder carry; beat value = {carry_out, result}, zero-extended to ACC_W
//   acc_out    out  ACC_W   batch total; stable while acc_valid=1
//   acc_valid  out  1       batch total available
//   out_ready  in   1       consumer takes acc_out
//   overflow   out  1       sticky per batch: accumulator exceeded 2^ACC_W-1
//   busy       out  1       high in ACCUM
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; acc_out=0, acc_valid=0, overflow=0, busy=0,
//     in_ready=0, beat count=0. Takes effect immediately, including mid-batch. The partial batch is discarded.
//   FSM states: IDLE, ACCUM, DONE.
//   IDLE: in_ready=0. On start=1, go to ACCUM next cycle and clear acc, count and overflow.
//   ACCUM: in_ready=1, busy=1. A beat transfers when in_valid&&in_ready. On a transfer:
//     acc <= acc + zext({carry_out,result}); count <= count+1.
//     If the (ACC_W+1)-bit sum has its MSB set, set overflow (sticky).
//     The transfer that makes count==COUNT_N moves to DONE next cycle. No extra latency.
//     in_valid=0 stalls indefinitely with no state change. start is ignored in ACCUM.
//   DONE: in_ready=0, acc_valid=1, and acc_out/overflow are held.
//     out_ready=1 completes the output transfer.
//     out_ready&&start together: go to ACCUM and clear acc/count/overflow (back-to-back batches).
//     out_ready with no start: go to IDLE. acc_out keeps its last value; acc_valid drops.
//     start without out_ready: ignored.
//   Latency: acc_valid rises exactly 1 cycle after the COUNT_N-th accepted beat.
//   Count register width: $clog2(COUNT_N+1). COUNT_N=1 gives one-beat batches.
//   Wrap (default): acc keeps the low ACC_W bits of the sum.
// CONFIGURATION
//   ACC_SATURATE_EN defined: when an add overflows, acc clamps to {ACC_W{1'b1}} and stays
//     clamped for the rest of the batch. overflow is still set.
//   ACC_SATURATE_EN undefined: modular wrap as described above. overflow is still set.
// STRUCTURE
//   Shared header adder_defs.vh:
//     - state encodings ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2
//     - default DATA_W and ACC_W constants, also used by eight_bit_adder benches
//   Sub-module acc_add_unit (combinational):
//     - inputs: acc, zero-extended beat
//     - outputs: next acc and overflow bit, with the saturate/wrap choice under ACC_SATURATE_EN
//   Top level holds the FSM, counter and registers.
// TESTING
//   1 Batch of 4 beats, in_valid held high, out_ready=1:
//     beats (0x31,c1),(0xFF,c0),(0x00,c1),(0x00,c0) = 305+255+256+0
//     -> acc_out=16'h0330, overflow=0. acc_valid exactly 1 cycle after beat 4.
//   2 Same batch with in_valid toggling every other cycle -> identical acc_out=0x0330.
//     in_ready stays 1; count advances only on transfers.
//   3 ACC_W=10, 4 beats of (0xFF,c1)=511 each:
//     wrap build -> acc_out=10'h3FC, overflow=1
//     ACC_SATURATE_EN build -> acc_out=10'h3FF, overflow=1
//   4 Reset mid-batch: assert rst_n=0 after 2 beats
//     -> all outputs 0 asynchronously, state IDLE.
//     A new start plus 4 beats of (0x01,c0) -> acc_out=4.
//   5 In DONE, hold out_ready=0 for 5 cycles:
//     acc_out, acc_valid and overflow stay stable; in_ready=0; start is ignored.
//     Then out_ready=1 with start=1 -> next batch starts with acc=0.
//   6 COUNT_N=1, single beat (0xFF,c1) -> acc_out=511, acc_valid on the next cycle.
//     start pulsed while in ACCUM has no effect.

Source files
------------

// File: rtl/adder_result_accumulator_pkg.sv
// Shared state encodings and default widths for the adder result accumulator and related benches.
package adder_result_accumulator_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_COUNT_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_result_accumulator_acc_add_unit.sv
// Combinational accumulate step: adds one zero-extended beat and reports carry out of ACC_W bits.
// ACC_SATURATE_EN selects clamp-to-all-ones instead of modular wrap on overflow.
module acc_add_unit #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_beat,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_overflow
);

  logic [ACC_W:0] w_sum;

  assign w_sum      = {1'b0, i_acc} + {1'b0, i_beat};
  assign o_overflow = w_sum[ACC_W];

`ifdef ACC_SATURATE_EN
  // Once clamped, any further non-zero beat overflows again, so the clamp persists.
  assign o_acc = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign o_acc = w_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/adder_result_accumulator.sv
// Sums batches of COUNT_N {carry_out,result} beats and presents the total over a handshake.
// Optional ACC_SATURATE_EN makes the accumulator saturate instead of wrapping.
module adder_result_accumulator
  import adder_result_accumulator_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int COUNT_N = DEF_COUNT_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] result,
  input  logic              carry_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = $clog2(COUNT_N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_N - 1);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_acc_valid;
  logic             r_busy;
  logic             r_in_ready;

  logic [ACC_W-1:0] w_beat;
  logic [ACC_W-1:0] w_next_acc;
  logic             w_add_ovf;
  logic             w_xfer;

  assign w_beat = ACC_W'({carry_out, result});
  assign w_xfer = in_valid && r_in_ready;

  acc_add_unit #(
    .ACC_W(ACC_W)
  ) u_add (
    .i_acc     (r_acc),
    .i_beat    (w_beat),
    .o_acc     (w_next_acc),
    .o_overflow(w_add_ovf)
  );

  // All handshake/status outputs are registered alongside the state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_acc_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_ACCUM;
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (w_xfer) begin
            r_acc   <= w_next_acc;
            r_count <= r_count + 1'b1;
            if (w_add_ovf) r_overflow <= 1'b1;
            if (r_count == LAST_CNT) begin
              r_state     <= ST_DONE;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b0;
              r_acc_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_acc_valid <= 1'b0;
            if (start) begin
              r_state    <= ST_ACCUM;
              r_acc      <= '0;
              r_count    <= '0;
              r_overflow <= 1'b0;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign acc_out   = r_acc;
  assign acc_valid = r_acc_valid;
  assign overflow  = r_overflow;
  assign busy      = r_busy;
  assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator: default batch, 10-bit wrap/saturate and one-beat instances.
module tb_adder_result_accumulator;

  logic clk = 1'b0;
  logic rst_n;

  // Main instance: DATA_W=8, ACC_W=16, COUNT_N=4
  logic        mStart, mInValid, mCarry, mOutReady;
  logic [7:0]  mResult;
  logic        mInReady, mAccValid, mOverflow, mBusy;
  logic [15:0] mAccOut;

  // Narrow instance: ACC_W=10, COUNT_N=4
  logic        sStart, sInValid, sCarry, sOutReady;
  logic [7:0]  sResult;
  logic        sInReady, sAccValid, sOverflow, sBusy;
  logic [9:0]  sAccOut;

  // One-beat instance: COUNT_N=1
  logic        uStart, uInValid, uCarry, uOutReady;
  logic [7:0]  uResult;
  logic        uInReady, uAccValid, uOverflow, uBusy;
  logic [15:0] uAccOut;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] beatRes [4] = '{8'h31, 8'hFF, 8'h00, 8'h00};
  logic       beatCar [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

`ifdef ACC_SATURATE_EN
  localparam logic [9:0] NARROW_FINAL = 10'h3FF;
  localparam logic [9:0] NARROW_BEAT3 = 10'h3FF;
`else
  localparam logic [9:0] NARROW_FINAL = 10'h3FC;
  localparam logic [9:0] NARROW_BEAT3 = 10'h1FD;
`endif

  always #5 clk = ~clk;

  adder_result_accumulator #(.DATA_W(8), .ACC_W(16), .COUNT_N(4)) dutMain (
    .clk(clk), .rst_n(rst_n), .start(mStart), .in_valid(mInValid), .in_ready(mInReady),
    .result(mResult), .carry_out(mCarry), .acc_out(mAccOut), .acc_valid(mAccValid),
    .out_ready(mOutReady), .overflow(mOverflow), .busy(mBusy));

  adder_result_accumulator #(.DATA_W(8), .ACC_W(10), .COUNT_N(4)) dutNarrow (
    .clk(clk), .rst_n(rst_n), .start(sStart), .in_valid(sInValid), .in_ready(sInReady),
    .result(sResult), .carry_out(sCarry), .acc_out(sAccOut), .acc_valid(sAccValid),
    .out_ready(sOutReady), .overflow(sOverflow), .busy(sBusy));

  adder_result_accumulator #(.DATA_W(8), .ACC_W(16), .COUNT_N(1)) dutOne (
    .clk(clk), .rst_n(rst_n), .start(uStart), .in_valid(uInValid), .in_ready(uInReady),
    .result(uResult), .carry_out(uCarry), .acc_out(uAccOut), .acc_valid(uAccValid),
    .out_ready(uOutReady), .overflow(uOverflow), .busy(uBusy));

  task automatic applyStimulus(input logic st, input logic iv, input logic [7:0] res,
                               input logic co, input logic ordy);
    mStart    = st;
    mInValid  = iv;
    mResult   = res;
    mCarry    = co;
    mOutReady = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkMainIdle(input string tag, input logic [15:0] expAcc);
    checkOutput({tag, " acc_out"}, 32'(mAccOut), 32'(expAcc));
    checkOutput({tag, " acc_valid"}, 32'(mAccValid), 32'd0);
    checkOutput({tag, " overflow"}, 32'(mOverflow), 32'd0);
    checkOutput({tag, " busy"}, 32'(mBusy), 32'd0);
    checkOutput({tag, " in_ready"}, 32'(mInReady), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    sStart = 0; sInValid = 0; sResult = 0; sCarry = 0; sOutReady = 0;
    uStart = 0; uInValid = 0; uResult = 0; uCarry = 0; uOutReady = 0;
    #2;
    $display("[TB] reset state");
    checkMainIdle("reset", 16'h0000);
    checkOutput("reset narrow acc_out", 32'(sAccOut), 32'd0);
    checkOutput("reset one acc_valid", 32'(uAccValid), 32'd0);
    #10 rst_n = 1'b1;
    step();

    $display("[TB] batch with in_valid held high");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    checkOutput("t1 busy", 32'(mBusy), 32'd1);
    checkOutput("t1 in_ready", 32'(mInReady), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, beatRes[i], beatCar[i], 1'b1);
      if (i == 3) checkOutput("t1 acc_valid before last", 32'(mAccValid), 32'd0);
      step();
    end
    checkOutput("t1 acc_valid", 32'(mAccValid), 32'd1);
    checkOutput("t1 acc_out", 32'(mAccOut), 32'h330);
    checkOutput("t1 overflow", 32'(mOverflow), 32'd0);
    checkOutput("t1 in_ready done", 32'(mInReady), 32'd0);
    checkOutput("t1 busy done", 32'(mBusy), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    checkMainIdle("t1 after take", 16'h0330);

    $display("[TB] batch with in_valid toggling");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 8'hAA, 1'b1, 1'b0);
      step();
      checkOutput("t2 in_ready stall", 32'(mInReady), 32'd1);
      checkOutput("t2 acc_valid stall", 32'(mAccValid), 32'd0);
      applyStimulus(1'b0, 1'b1, beatRes[i], beatCar[i], 1'b0);
      step();
    end
    checkOutput("t2 acc_out", 32'(mAccOut), 32'h330);
    checkOutput("t2 acc_valid", 32'(mAccValid), 32'd1);

    $display("[TB] hold in DONE with out_ready low");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
      step();
      checkOutput("t5 acc_out held", 32'(mAccOut), 32'h330);
      checkOutput("t5 acc_valid held", 32'(mAccValid), 32'd1);
      checkOutput("t5 overflow held", 32'(mOverflow), 32'd0);
      checkOutput("t5 in_ready", 32'(mInReady), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    checkOutput("t5 restart acc_out", 32'(mAccOut), 32'd0);
    checkOutput("t5 restart busy", 32'(mBusy), 32'd1);
    checkOutput("t5 restart acc_valid", 32'(mAccValid), 32'd0);

    $display("[TB] reset mid-batch");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h10, 1'b1, 1'b0);
      step();
    end
    checkOutput("t4 partial acc_out", 32'(mAccOut), 32'h220);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checkMainIdle("t4 async reset", 16'h0000);
    #2 rst_n = 1'b1;
    step();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
      step();
    end
    checkOutput("t4 acc_out", 32'(mAccOut), 32'd4);
    checkOutput("t4 acc_valid", 32'(mAccValid), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step();

    $display("[TB] narrow accumulator overflow");
    sStart = 1'b1;
    step();
    sStart = 1'b0; sInValid = 1'b1; sResult = 8'hFF; sCarry = 1'b1;
    step();
    step();
    checkOutput("t3 beat2 acc_out", 32'(sAccOut), 32'h3FE);
    checkOutput("t3 beat2 overflow", 32'(sOverflow), 32'd0);
    step();
    checkOutput("t3 beat3 acc_out", 32'(sAccOut), 32'(NARROW_BEAT3));
    checkOutput("t3 beat3 overflow", 32'(sOverflow), 32'd1);
    step();
    sInValid = 1'b0;
    checkOutput("t3 acc_out", 32'(sAccOut), 32'(NARROW_FINAL));
    checkOutput("t3 overflow", 32'(sOverflow), 32'd1);
    checkOutput("t3 acc_valid", 32'(sAccValid), 32'd1);

    $display("[TB] one-beat batches");
    uStart = 1'b1;
    step();
    uInValid = 1'b0;
    step();
    checkOutput("t6 busy after start in accum", 32'(uBusy), 32'd1);
    checkOutput("t6 acc_out after start in accum", 32'(uAccOut), 32'd0);
    checkOutput("t6 acc_valid while waiting", 32'(uAccValid), 32'd0);
    uStart = 1'b0; uInValid = 1'b1; uResult = 8'hFF; uCarry = 1'b1;
    step();
    uInValid = 1'b0;
    checkOutput("t6 acc_valid", 32'(uAccValid), 32'd1);
    checkOutput("t6 acc_out", 32'(uAccOut), 32'd511);
    uOutReady = 1'b1;
    step();
    checkOutput("t6 acc_valid dropped", 32'(uAccValid), 32'd0);
    checkOutput("t6 acc_out kept", 32'(uAccOut), 32'd511);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
